// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: control-word layout, opcodes
// and forward-select codes. Used by ctrl_decode and pipe_control.
package pipe_ctrl_pkg;

   localparam int CTRL_W = 10;

   // Bit positions inside the control word
   localparam int CB_REGWRITE = 0;
   localparam int CB_MEMWRITE = 1;
   localparam int CB_MEMREAD  = 2;
   localparam int CB_MEMTOREG = 3;
   localparam int CB_BRANCH   = 4;
   localparam int CB_ALUSRC   = 5;
   localparam int CB_LXB      = 6;
   localparam int CB_PCSTORE  = 7;
   localparam int CB_BR       = 8;
   localparam int CB_HALT     = 9;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_SW  = 4'b1001;
   localparam logic [3:0] OP_LLB = 4'b1010;
   localparam logic [3:0] OP_LHB = 4'b1011;
   localparam logic [3:0] OP_B   = 4'b1100;
   localparam logic [3:0] OP_BR  = 4'b1101;
   localparam logic [3:0] OP_PCS = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: produces the control word and which source
// register fields the instruction actually reads.
module ctrl_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [3:0]        opcode,
   output logic [CTRL_W-1:0] ctrl,
   output logic              rs_used,
   output logic              rt_used
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      ctrl    = '0;
      rs_used = 1'b0;
      rt_used = 1'b0;

      ctrl[CB_REGWRITE] = ~opcode[3] | (opcode == OP_LW) | (opcode == OP_LLB) |
                          (opcode == OP_LHB) | (opcode == OP_PCS);
      ctrl[CB_MEMWRITE] = (opcode == OP_SW);
      ctrl[CB_MEMREAD]  = (opcode == OP_LW);
      ctrl[CB_MEMTOREG] = (opcode == OP_LW);
      ctrl[CB_BRANCH]   = (opcode[3:1] == 3'b110);
      ctrl[CB_ALUSRC]   = (opcode[3:1] == 3'b010) | (opcode == 4'b0110) | opcode[3];
      ctrl[CB_LXB]      = (opcode[3:1] == 3'b101);
      ctrl[CB_PCSTORE]  = (opcode[3:2] == 2'b11);
      ctrl[CB_BR]       = (opcode == OP_BR);
      ctrl[CB_HALT]     = (opcode == OP_HLT);

      // rs feeds every compute op, memory and LxB op, plus BR; rt only the
      // two-register compute ops and the SW store data
      rs_used = (opcode <= OP_LHB) | (opcode == OP_BR);
      rt_used = (opcode <= 4'b0011) | (opcode == 4'b0111) | (opcode == OP_SW);
   end

endmodule

// File: rtl/pipe_control.sv
// Pipeline controller: carries decoded control words ID->EX->MEM->WB and
// resolves hazards, halt and flush. Define CTRL_FWD_EN to enable EX operand
// forwarding (only load-use stalls remain); otherwise RAW hazards stall.
module pipe_control
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 4,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [3:0]            id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  flush_i,
   output logic [CTRL_W-1:0]     ex_ctrl_o,
   output logic [CTRL_W-1:0]     mem_ctrl_o,
   output logic [CTRL_W-1:0]     wb_ctrl_o,
   output logic [REG_ADDR_W-1:0] wb_rd_o,
   output logic                  stall_o,
   output logic [1:0]            fwd_a_o,
   output logic [1:0]            fwd_b_o,
   output logic                  halted_o
);

   logic [CTRL_W-1:0]     id_ctrl;
   logic                  id_rs_used, id_rt_used;

   logic                  ex_valid, mem_valid, wb_valid;
   logic [CTRL_W-1:0]     ex_ctrl, mem_ctrl, wb_ctrl;
   logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
   logic                  halted;

   logic                  ex_live, mem_live, wb_live;
   logic                  hazard, hlt_in_flight, ex_load;

   ctrl_decode u_decode (
      .opcode  (id_opcode),
      .ctrl    (id_ctrl),
      .rs_used (id_rs_used),
      .rt_used (id_rt_used)
   );

   // A used source matches a destination unless it is the hardwired R0
   function automatic logic src_match(input logic                  used,
                                      input logic [REG_ADDR_W-1:0] src,
                                      input logic [REG_ADDR_W-1:0] dst);
      return used && (src == dst) && !((ZERO_REG != 0) && (src == '0));
   endfunction

   // Halt empties the pipe at once, so stage valids are qualified here
   assign ex_live  = ex_valid  & ~halted;
   assign mem_live = mem_valid & ~halted;
   assign wb_live  = wb_valid  & ~halted;

   always_comb begin
      logic reads_ex;
      reads_ex = id_valid & (src_match(id_rs_used, id_rs, ex_rd) |
                             src_match(id_rt_used, id_rt, ex_rd));
`ifdef CTRL_FWD_EN
      hazard = ex_live & ex_ctrl[CB_MEMREAD] & reads_ex;
`else
      begin
         logic reads_mem;
         reads_mem = id_valid & (src_match(id_rs_used, id_rs, mem_rd) |
                                 src_match(id_rt_used, id_rt, mem_rd));
         hazard = (ex_live  & ex_ctrl[CB_REGWRITE]  & reads_ex) |
                  (mem_live & mem_ctrl[CB_REGWRITE] & reads_mem);
      end
`endif
   end

   assign hlt_in_flight = (ex_live & ex_ctrl[CB_HALT]) | (mem_live & mem_ctrl[CB_HALT]);
   assign stall_o       = halted | (hazard & ~flush_i);
   assign ex_load       = id_valid & ~hazard & ~flush_i & ~hlt_in_flight & ~halted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         mem_valid <= 1'b0;
         wb_valid  <= 1'b0;
         ex_ctrl   <= '0;
         mem_ctrl  <= '0;
         wb_ctrl   <= '0;
         ex_rd     <= '0;
         mem_rd    <= '0;
         wb_rd     <= '0;
         halted    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the
         // pre-edge value of the stage before it.
         ex_valid <= ex_load;
         if (ex_load) begin
            ex_ctrl <= id_ctrl;
            ex_rd   <= id_rd;
         end
         mem_valid <= ex_live;
         mem_ctrl  <= ex_ctrl;
         mem_rd    <= ex_rd;
         wb_valid  <= mem_live;
         wb_ctrl   <= mem_ctrl;
         wb_rd     <= mem_rd;
         halted    <= halted | (wb_live & wb_ctrl[CB_HALT]);
      end
   end

   assign ex_ctrl_o  = ex_live  ? ex_ctrl  : '0;
   assign mem_ctrl_o = mem_live ? mem_ctrl : '0;
   assign wb_ctrl_o  = wb_live  ? wb_ctrl  : '0;
   assign wb_rd_o    = wb_live  ? wb_rd    : '0;
   assign halted_o   = halted;

`ifdef CTRL_FWD_EN
   logic [REG_ADDR_W-1:0] ex_rs, ex_rt;
   logic                  ex_rs_used, ex_rt_used;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rs_used <= 1'b0;
         ex_rt_used <= 1'b0;
      end else if (ex_load) begin
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rs_used <= id_rs_used;
         ex_rt_used <= id_rt_used;
      end
   end

   // MEM holds the younger result, so it wins over WB
   always_comb begin
      fwd_a_o = FWD_NONE;
      fwd_b_o = FWD_NONE;
      if (ex_live) begin
         if (mem_live && mem_ctrl[CB_REGWRITE] && src_match(ex_rs_used, ex_rs, mem_rd))
            fwd_a_o = FWD_MEM;
         else if (wb_live && wb_ctrl[CB_REGWRITE] && src_match(ex_rs_used, ex_rs, wb_rd))
            fwd_a_o = FWD_WB;
         if (mem_live && mem_ctrl[CB_REGWRITE] && src_match(ex_rt_used, ex_rt, mem_rd))
            fwd_b_o = FWD_MEM;
         else if (wb_live && wb_ctrl[CB_REGWRITE] && src_match(ex_rt_used, ex_rt, wb_rd))
            fwd_b_o = FWD_WB;
      end
   end
`else
   assign fwd_a_o = FWD_NONE;
   assign fwd_b_o = FWD_NONE;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: directed instruction streams push the
// expected WB retirement; a monitor pops and compares each WB output.
module tb_pipe_control;
   import pipe_ctrl_pkg::*;

   localparam int AW = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              id_valid;
   logic [3:0]        id_opcode;
   logic [AW-1:0]     id_rs, id_rt, id_rd;
   logic              flush_i;
   logic [CTRL_W-1:0] ex_ctrl_o, mem_ctrl_o, wb_ctrl_o;
   logic [AW-1:0]     wb_rd_o;
   logic              stall_o;
   logic [1:0]        fwd_a_o, fwd_b_o;
   logic              halted_o;

   pipe_control #(.REG_ADDR_W(AW), .ZERO_REG(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_opcode  (id_opcode),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rd      (id_rd),
      .flush_i    (flush_i),
      .ex_ctrl_o  (ex_ctrl_o),
      .mem_ctrl_o (mem_ctrl_o),
      .wb_ctrl_o  (wb_ctrl_o),
      .wb_rd_o    (wb_rd_o),
      .stall_o    (stall_o),
      .fwd_a_o    (fwd_a_o),
      .fwd_b_o    (fwd_b_o),
      .halted_o   (halted_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [CTRL_W-1:0] ctrl;
      logic [AW-1:0]     rd;
      int                at;
   } exp_t;
   exp_t sb[$];

   // Hand-computed control words
   localparam logic [CTRL_W-1:0] W_ADD = 10'h001;
   localparam logic [CTRL_W-1:0] W_LW  = 10'h02D;
   localparam logic [CTRL_W-1:0] W_SW  = 10'h022;
   localparam logic [CTRL_W-1:0] W_LLB = 10'h061;
   localparam logic [CTRL_W-1:0] W_B   = 10'h0B0;
   localparam logic [CTRL_W-1:0] W_BR  = 10'h1B0;
   localparam logic [CTRL_W-1:0] W_PCS = 10'h0A1;
   localparam logic [CTRL_W-1:0] W_ADI = 10'h021;
   localparam logic [CTRL_W-1:0] W_HLT = 10'h2A0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // One ID cycle: drive at negedge, check stall, record expected retirement
   task automatic drive(input logic v, input logic [3:0] op,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic fl,
                        input logic exp_stall, input logic retire,
                        input logic [CTRL_W-1:0] exp_ctrl, input string name);
      exp_t e;
      @(negedge clk);
      id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; flush_i = fl;
      #1;
      check({name, "_stall"}, 32'(stall_o), 32'(exp_stall));
      if (retire) begin
         e.ctrl = exp_ctrl; e.rd = rd; e.at = cyc + 3;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n, input logic exp_stall);
      for (int i = 0; i < n; i++) drive(1'b0, 4'h0, '0, '0, '0, 1'b0, exp_stall, 1'b0, '0, "idle");
   endtask

   // Monitor: every non-empty WB word must match the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (wb_ctrl_o !== '0) begin
            if (sb.size() == 0) begin
               check("wb_unexpected", 32'(wb_ctrl_o), 32'h0);
            end else begin
               e = sb.pop_front();
               check("wb_ctrl", 32'(wb_ctrl_o), 32'(e.ctrl));
               check("wb_rd", 32'(wb_rd_o), 32'(e.rd));
               check("wb_cycle", 32'(cyc), 32'(e.at));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0;
      flush_i = 1'b0;
      #12;
      check("rst_ex_ctrl", 32'(ex_ctrl_o), 0);
      check("rst_wb_ctrl", 32'(wb_ctrl_o), 0);
      check("rst_wb_rd", 32'(wb_rd_o), 0);
      check("rst_stall", 32'(stall_o), 0);
      check("rst_halted", 32'(halted_o), 0);
      check("rst_fwd", 32'({fwd_a_o, fwd_b_o}), 0);
      @(negedge clk); rst_n = 1'b1;

      // ADD R1 then idle: retires at issue+3
      drive(1, OP_ADD, 0, 0, 1, 0, 0, 1, W_ADD, "add1");
      idle(3, 0);

      // Independent decode sweep (R0 sources never hazard)
      drive(1, OP_LW,   0, 0, 9,  0, 0, 1, W_LW,  "lw9");
      drive(1, OP_SW,   0, 0, 10, 0, 0, 1, W_SW,  "sw");
      drive(1, OP_LLB,  0, 0, 11, 0, 0, 1, W_LLB, "llb");
      drive(1, OP_B,    0, 0, 12, 0, 0, 1, W_B,   "b");
      drive(1, OP_BR,   0, 0, 13, 0, 0, 1, W_BR,  "br");
      drive(1, OP_PCS,  0, 0, 14, 0, 0, 1, W_PCS, "pcs");
      drive(1, 4'b0100, 0, 0, 15, 0, 0, 1, W_ADI, "addi");
      idle(3, 0);

      // LW R2 ; ADD R3,R2,R4
      drive(1, OP_LW, 0, 0, 2, 0, 0, 1, W_LW, "lw2");
      drive(1, OP_ADD, 2, 4, 3, 0, 1, 0, W_ADD, "lu_stall1");
`ifdef CTRL_FWD_EN
      drive(1, OP_ADD, 2, 4, 3, 0, 0, 1, W_ADD, "lu_go");
`else
      drive(1, OP_ADD, 2, 4, 3, 0, 1, 0, W_ADD, "lu_stall2");
      drive(1, OP_ADD, 2, 4, 3, 0, 0, 1, W_ADD, "lu_go");
`endif
      idle(3, 0);

      // ADD R5 ; SUB R6,R5,R5 and the one-gap variant
`ifdef CTRL_FWD_EN
      drive(1, OP_ADD, 0, 0, 5, 0, 0, 1, W_ADD, "add5");
      drive(1, OP_SUB, 5, 5, 6, 0, 0, 1, W_ADD, "sub6");
      idle(1, 0);
      check("fwd_a_mem", 32'(fwd_a_o), 32'(2'b10));
      check("fwd_b_mem", 32'(fwd_b_o), 32'(2'b10));
      drive(1, OP_ADD, 0, 0, 7, 0, 0, 1, W_ADD, "add7");
      idle(1, 0);
      drive(1, OP_SUB, 7, 7, 8, 0, 0, 1, W_ADD, "sub8");
      idle(1, 0);
      check("fwd_a_wb", 32'(fwd_a_o), 32'(2'b01));
      check("fwd_b_wb", 32'(fwd_b_o), 32'(2'b01));
      idle(1, 0);
      check("fwd_a_none", 32'(fwd_a_o), 0);
      drive(1, OP_ADD, 0, 0, 9, 0, 0, 1, W_ADD, "add9a");
      drive(1, OP_ADD, 0, 0, 9, 0, 0, 1, W_ADD, "add9b");
      drive(1, OP_SUB, 9, 0, 10, 0, 0, 1, W_ADD, "sub10");
      idle(1, 0);
      check("fwd_a_prio", 32'(fwd_a_o), 32'(2'b10));
      idle(3, 0);
`else
      drive(1, OP_ADD, 0, 0, 5, 0, 0, 1, W_ADD, "add5");
      drive(1, OP_SUB, 5, 5, 6, 0, 1, 0, W_ADD, "raw_ex");
      drive(1, OP_SUB, 5, 5, 6, 0, 1, 0, W_ADD, "raw_mem");
      drive(1, OP_SUB, 5, 5, 6, 0, 0, 1, W_ADD, "sub6");
      idle(1, 0);
      check("fwd_a_tied", 32'(fwd_a_o), 0);
      check("fwd_b_tied", 32'(fwd_b_o), 0);
      drive(1, OP_ADD, 0, 0, 7, 0, 0, 1, W_ADD, "add7");
      idle(1, 0);
      drive(1, OP_SUB, 7, 7, 8, 0, 1, 0, W_ADD, "raw_gap");
      drive(1, OP_SUB, 7, 7, 8, 0, 0, 1, W_ADD, "sub8");
      idle(3, 0);
`endif

      // Load-use hazard squashed by flush: no stall, ADD never retires
      drive(1, OP_LW, 0, 0, 2, 0, 0, 1, W_LW, "lw2f");
      drive(1, OP_ADD, 2, 4, 3, 1, 0, 0, W_ADD, "flush");
      idle(3, 0);

      // R0 destination never hazards
      drive(1, OP_LW, 0, 0, 0, 0, 0, 1, W_LW, "lw0");
      drive(1, OP_ADD, 0, 0, 1, 0, 0, 1, W_ADD, "add_r0");
      idle(3, 0);

      // Reset in the middle of a stall drops it immediately
      drive(1, OP_LW, 0, 0, 2, 0, 0, 0, W_LW, "lw_rst");
      drive(1, OP_ADD, 2, 4, 3, 0, 1, 0, W_ADD, "stall_rst");
      rst_n = 1'b0; id_valid = 1'b0;
      #1;
      check("rst_mid_stall", 32'(stall_o), 0);
      check("rst_mid_ex", 32'(ex_ctrl_o), 0);
      @(negedge clk); rst_n = 1'b1;
      idle(2, 0);

      // HLT: younger instructions bubbled, halted_o rises 4 cycles after issue
      drive(1, OP_HLT, 0, 0, 0, 0, 0, 1, W_HLT, "hlt");
      drive(1, OP_ADD, 0, 0, 1, 0, 0, 0, W_ADD, "hlt_ex_bub");
      check("halted_c1", 32'(halted_o), 0);
      drive(1, OP_ADD, 0, 0, 1, 0, 0, 0, W_ADD, "hlt_mem_bub");
      check("halted_c2", 32'(halted_o), 0);
      idle(1, 0);
      check("halted_c3", 32'(halted_o), 0);
      idle(1, 1);
      check("halted_c4", 32'(halted_o), 1);
      drive(1, OP_ADD, 0, 0, 1, 0, 1, 0, W_ADD, "halted_hold");
      check("halted_c5", 32'(halted_o), 1);
      check("halted_mem", 32'(mem_ctrl_o), 0);
      rst_n = 1'b0; id_valid = 1'b0;
      #1;
      check("halt_rst", 32'(halted_o), 0);
      check("halt_rst_stall", 32'(stall_o), 0);
      @(negedge clk); rst_n = 1'b1;

      idle(4, 0);
      check("sb_empty", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
